// File: rtl/serial_sub.sv
// Bit-serial two's-complement subtractor D = A - B - Bin, LSB first, one full-subtractor cell.
// Latency: start edge N -> done pulse N+WIDTH; start accepted only in IDLE, otherwise dropped.
// Optional SUB_OVF_EN adds the registered signed-overflow output Ovf.
module serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    input  logic             start,
    input  logic             E,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             Bout
`ifdef SUB_OVF_EN
    ,
    output logic             Ovf
`endif
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic             bw;
    logic [WIDTH-1:0] d_reg;
    logic             bout_reg;
    logic             d_bit;
    logic             bw_nxt;
    logic             last;

    always_comb begin
        d_bit  = sa[0] ^ sb[0] ^ bw;
        bw_nxt = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & bw);
        last   = (cnt == CW'(WIDTH - 1));
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (last) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

`ifdef SUB_OVF_EN
    logic a_msb;
    logic b_msb;
    logic ovf_reg;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            sa       <= '0;
            sb       <= '0;
            bw       <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            d_reg    <= '0;
            bout_reg <= 1'b0;
`ifdef SUB_OVF_EN
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            ovf_reg  <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        sa   <= A;
                        sb   <= B;
                        bw   <= Bin;
                        cnt  <= '0;
                        busy <= 1'b1;
`ifdef SUB_OVF_EN
                        a_msb <= A[WIDTH-1];
                        b_msb <= B[WIDTH-1];
`endif
                    end
                end
                S_RUN: begin
                    // Result bits fill the minuend register from the top as its operand bits leave
                    sa  <= {d_bit, sa[WIDTH-1:1]};
                    sb  <= {1'b0, sb[WIDTH-1:1]};
                    bw  <= bw_nxt;
                    cnt <= cnt + CW'(1);
                    if (last) begin
                        d_reg    <= {d_bit, sa[WIDTH-1:1]};
                        bout_reg <= bw_nxt;
                        busy     <= 1'b0;
                        done     <= 1'b1;
`ifdef SUB_OVF_EN
                        ovf_reg  <= (a_msb ^ b_msb) & (a_msb ^ d_bit);
`endif
                    end
                end
                S_DONE: begin
                    done <= 1'b0;
                end
                default: begin
                    busy <= 1'b0;
                    done <= 1'b0;
                end
            endcase
        end
    end

    assign D    = E ? {WIDTH{1'bz}} : d_reg;
    assign Bout = E ? 1'bz : bout_reg;
`ifdef SUB_OVF_EN
    assign Ovf  = E ? 1'bz : ovf_reg;
`endif

endmodule

// File: tb/tb_serial_sub.sv
// Directed bench for serial_sub (WIDTH=8); defines SUB_OVF_EN to also check Ovf.
module tb_serial_sub;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] A;
    logic [7:0] B;
    logic       Bin;
    logic       start;
    logic       E;
    wire        busy;
    wire        done;
    wire  [7:0] D;
    wire        Bout;
`ifdef SUB_OVF_EN
    wire        Ovf;
`endif

    int asserts = 0;
    int fails   = 0;

    serial_sub #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .A     (A),
        .B     (B),
        .Bin   (Bin),
        .start (start),
        .E     (E),
        .busy  (busy),
        .done  (done),
        .D     (D),
        .Bout  (Bout)
`ifdef SUB_OVF_EN
        ,
        .Ovf   (Ovf)
`endif
    );

    always #5 clk = ~clk;

    // Starts one op and returns the number of edges from the start edge until done is seen.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic bin,
                          output int lat);
        A     = a;
        B     = b;
        Bin   = bin;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1 lat++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; E = 1'b0; A = '0; B = '0; Bin = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        asserts++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            fails++; $display("FAIL reset_ctl: busy=%b done=%b want 0 0", busy, done);
        end
        asserts++;
        if (D !== 8'h00 || Bout !== 1'b0) begin
            fails++; $display("FAIL reset_out: D=%h Bout=%b want 00 0", D, Bout);
        end
    endtask

    task automatic test_basic;
        int lat;
        @(posedge clk); #1;
        A = 8'h5A; B = 8'h3C; Bin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        asserts++;
        if (busy !== 1'b1) begin
            fails++; $display("FAIL t1_busy: busy=%b want 1", busy);
        end
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1 lat++;
        end
        asserts++;
        if (lat != 8) begin
            fails++; $display("FAIL t1_latency: got %0d edges want 8", lat);
        end
        asserts++;
        if (D !== 8'h1E || Bout !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL t1_result: D=%h Bout=%b busy=%b want 1e 0 0", D, Bout, busy);
        end
        @(posedge clk); #1;
        asserts++;
        if (done !== 1'b0 || D !== 8'h1E) begin
            fails++; $display("FAIL t1_pulse_hold: done=%b D=%h want 0 1e", done, D);
        end
    endtask

    task automatic test_borrow;
        int lat;
        @(posedge clk); #1;
        run_op(8'h00, 8'h01, 1'b0, lat);
        asserts++;
        if (lat != 8 || D !== 8'hFF || Bout !== 1'b1) begin
            fails++; $display("FAIL t2_borrow: lat=%0d D=%h Bout=%b want 8 ff 1", lat, D, Bout);
        end
        @(posedge clk); #1;
        run_op(8'h10, 8'h0F, 1'b1, lat);
        asserts++;
        if (lat != 8 || D !== 8'h00 || Bout !== 1'b0) begin
            fails++; $display("FAIL t3_bin_zero: lat=%0d D=%h Bout=%b want 8 00 0", lat, D, Bout);
        end
        @(posedge clk); #1;
        run_op(8'h00, 8'h00, 1'b1, lat);
        asserts++;
        if (lat != 8 || D !== 8'hFF || Bout !== 1'b1) begin
            fails++; $display("FAIL t3_bin_wrap: lat=%0d D=%h Bout=%b want 8 ff 1", lat, D, Bout);
        end
    endtask

    task automatic test_tristate;
        int lat;
        @(posedge clk); #1;
        run_op(8'h5A, 8'h3C, 1'b0, lat);
        E = 1'b1;
        #1;
        // A two-state simulator reads an undriven net as 0, so accept that rendering too
        asserts++;
        if (!((D === 8'hzz && Bout === 1'bz) || (D === 8'h00 && Bout === 1'b0))) begin
            fails++; $display("FAIL t4_hiz: D=%h Bout=%b want zz z", D, Bout);
        end
        asserts++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            fails++; $display("FAIL t4_ctl_driven: done=%b busy=%b want 1 0", done, busy);
        end
        @(posedge clk); #1;
        E = 1'b0;
        #1;
        asserts++;
        if (D !== 8'h1E || Bout !== 1'b0 || done !== 1'b0) begin
            fails++; $display("FAIL t4_redrive: D=%h Bout=%b done=%b want 1e 0 0", D, Bout, done);
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        @(posedge clk); #1;
        run_op(8'h80, 8'h7F, 1'b0, lat);
        // start raised during the DONE cycle must be dropped
        A = 8'hFF; B = 8'h00; Bin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        asserts++;
        if (busy !== 1'b0 || done !== 1'b0 || D !== 8'h01) begin
            fails++; $display("FAIL bb_done_start: busy=%b done=%b D=%h want 0 0 01", busy, done, D);
        end
        run_op(8'hC3, 8'h3C, 1'b1, lat);
        asserts++;
        if (lat != 8 || D !== 8'h86 || Bout !== 1'b0) begin
            fails++; $display("FAIL bb_second: lat=%0d D=%h Bout=%b want 8 86 0", lat, D, Bout);
        end
        // Toggle E while running; the result must be unaffected
        @(posedge clk); #1;
        A = 8'h01; B = 8'h02; Bin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) begin
            E = ~E;
            @(posedge clk); #1;
        end
        E = 1'b0;
        lat = 3;
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1 lat++;
        end
        asserts++;
        if (lat != 8 || D !== 8'hFF || Bout !== 1'b1) begin
            fails++; $display("FAIL bb_e_toggle: lat=%0d D=%h Bout=%b want 8 ff 1", lat, D, Bout);
        end
    endtask

    task automatic test_abort;
        int  lat;
        bit  seen_done;
        @(posedge clk); #1;
        A = 8'h5A; B = 8'h3C; Bin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #1 A = 8'hFF; B = 8'h00; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        asserts++;
        if (busy !== 1'b1) begin
            fails++; $display("FAIL t5_busy_kept: busy=%b want 1", busy);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        asserts++;
        if (busy !== 1'b0 || done !== 1'b0 || D !== 8'h00 || Bout !== 1'b0) begin
            fails++; $display("FAIL t5_after_rst: busy=%b done=%b D=%h Bout=%b want 0 0 00 0",
                              busy, done, D, Bout);
        end
        seen_done = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) seen_done = 1'b1;
        end
        asserts++;
        if (seen_done) begin
            fails++; $display("FAIL t5_no_done: activity=%b want 0", seen_done);
        end
        run_op(8'h5A, 8'h3C, 1'b0, lat);
        asserts++;
        if (lat != 8 || D !== 8'h1E || Bout !== 1'b0) begin
            fails++; $display("FAIL t5_fresh: lat=%0d D=%h Bout=%b want 8 1e 0", lat, D, Bout);
        end
    endtask

`ifdef SUB_OVF_EN
    task automatic test_overflow;
        int lat;
        @(posedge clk); #1;
        run_op(8'h80, 8'h01, 1'b0, lat);
        asserts++;
        if (lat != 8 || D !== 8'h7F || Bout !== 1'b0 || Ovf !== 1'b1) begin
            fails++; $display("FAIL t6_ovf_set: D=%h Bout=%b Ovf=%b want 7f 0 1", D, Bout, Ovf);
        end
        @(posedge clk); #1;
        run_op(8'h05, 8'h03, 1'b0, lat);
        asserts++;
        if (lat != 8 || D !== 8'h02 || Ovf !== 1'b0) begin
            fails++; $display("FAIL t6_ovf_clr: D=%h Ovf=%b want 02 0", D, Ovf);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_borrow();
        test_tristate();
        test_back_to_back();
        test_abort();
`ifdef SUB_OVF_EN
        test_overflow();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
